keycode_event_queue: RTL and testbench
======================================

// Module: keycode_event_queue
// PURPOSE
//  Sits between the SoC keycode PIO export and the ball motion logic.
//  - Filters the raw 8-bit keycode and turns changes into press/release events in a small FIFO.
//  - Presents a frame-latched keycode that stays stable for a whole video frame.
//  - Generates a one-cycle frame tick from the vertical sync.
// PARAMETERS
//  DEPTH       8   FIFO entries; power of two, >=2
//  STABLE_CYC  4   cycles keycode_in must hold a new value before it is accepted (>=1)
// PORTS
//  Clk           in   1  system clock, 50 MHz
//  Reset_n       in   1  asynchronous, active-low reset
//  keycode_in    in   8  raw keycode from PIO; 8'h00 = no key
//  frame_vs      in   1  VGA vertical sync, active low, asynchronous to Clk
//  evt_ready     in   1  consumer pops the head event when evt_valid=1
//  ovf_clr       in   1  clears the overflow flag
//  evt_valid     out  1  FIFO not empty
//  evt_data      out  9  head event {press(1)/release(0), code[7:0]}
//  evt_count     out  $clog2(DEPTH)+1  current occupancy
//  overflow      out  1  sticky: an event was dropped because the FIFO was full
//  frame_tick    out  1  one-cycle pulse per frame
//  frame_key     out  8  accepted key, sampled on frame_tick
// BEHAVIOUR
//  Reset
//  - All outputs are 0.
//  - FIFO is empty, and the accepted key (cur_key) is 8'h00.
//  - FSM is in IDLE, stability counter is 0, and the vs synchronizer is preset to 1.
//  Filter
//  - keycode_in is registered once.
//  - When the registered value differs from cand, cand is loaded and cnt is cleared.
//  - Otherwise cnt increments, saturating.
//  - When cnt reaches STABLE_CYC-1 and cand != cur_key, a change is raised to the FSM.
//  - A change is consumed only when the FSM is in IDLE; otherwise it waits.
//  Event FSM (IDLE, REL, PRS)
//  - IDLE, change pending: latch old=cur_key and new=cand, set cur_key<=cand.
//    Next state is REL if old!=0, else PRS if new!=0.
//  - REL: push {0,old}. Next state is PRS if new!=0, else IDLE.
//  - PRS: push {1,new}. Next state is IDLE.
//  - Each push takes exactly one cycle, so a key-to-key change yields a release then a press, in order.
//  FIFO
//  - Write in the push cycle; the entry is visible at evt_data the next cycle.
//  - Pop when evt_valid && evt_ready; the head advances the next cycle.
//  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  - evt_count = writes - pops and never exceeds DEPTH.
//  - Push while full with no pop: the event is dropped, overflow<=1, and the FSM still advances.
//  - Push and pop in the same cycle while full: both are accepted and the count is unchanged.
//  - Push and pop in the same cycle while empty: only the push occurs.
//  - Pop while empty: ignored.
//  - ovf_clr clears overflow. A drop in the same cycle as ovf_clr wins (overflow=1).
//  Frame
//  - frame_vs passes through a 2-flop synchronizer.
//  - frame_tick=1 for exactly one cycle on each synchronized 1->0 edge (the same cycle the edge is seen).
//  - frame_key<=cur_key on that cycle, and holds otherwise.
//  - Latency from a frame_vs fall to frame_tick is 2-3 cycles.
//  Reset mid-operation
//  - Reset discards all queued events and any pending change, and returns the block to its reset state immediately.
// TESTING
//  1) keycode_in 00->1A, held 10 cycles -> exactly one event {1,1A}, evt_count=1, no release event.
//  2) 1A->07, held -> events {0,1A} then {1,07} in consecutive cycles; popping yields that order.
//  3) keycode_in glitch 00->1A->00 lasting STABLE_CYC-1 cycles -> no event, cur_key stays 00.
//  4) 9 changes between non-zero keys, no pops, DEPTH=8 -> evt_count=8, overflow=1, head is the first release.
//     Then ovf_clr -> overflow=0; simultaneous push+pop while full -> evt_count stays 8.
//  5) frame_vs falls while cur_key=1A -> single frame_tick within 3 cycles, frame_key=1A.
//     Key changes mid-frame -> frame_key is unchanged until the next tick.
//  6) Reset_n asserted with 3 queued events -> evt_valid=0, evt_count=0 immediately; no events after release until a new change.

Source files
------------

// File: rtl/keycode_event_queue.sv
// Keycode front end: debounces the PIO keycode, queues press/release events,
// and latches a per-frame key snapshot on a synchronized vsync falling edge.
package keycode_event_queue_pkg;
  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } kevt_t;
endpackage

module keycode_event_queue
  import keycode_event_queue_pkg::*;
#(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [7:0]               keycode_in,
  input  logic                     frame_vs,
  input  logic                     evt_ready,
  input  logic                     ovf_clr,
  output logic                     evt_valid,
  output logic [8:0]               evt_data,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow,
  output logic                     frame_tick,
  output logic [7:0]               frame_key
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned OCC_W  = PTR_W + 1;
  localparam int unsigned SCNT_W = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STABLE_CYC - 1);
  localparam logic [OCC_W-1:0]  OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REL, PRS} state_e;

  state_e            state_q, state_d;
  logic [7:0]        kc_q, kc_d;
  logic [7:0]        cand_q, cand_d;
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [7:0]        cur_key_q, cur_key_d;
  logic [7:0]        old_q, old_d;
  logic [7:0]        new_q, new_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              evt_valid_q, evt_valid_d;
  logic              overflow_q, overflow_d;
  logic              meta_q, meta_d;
  logic              sync_q, sync_d;
  logic              tick_q, tick_d;
  logic [7:0]        frame_key_q, frame_key_d;
  kevt_t             mem_q [DEPTH];

  logic              change_c;
  logic              push_c;
  logic              pop_c;
  logic              full_c;
  logic              wr_c;
  logic              drop_c;
  kevt_t             push_data_c;

  // Next-state logic for filter, event FSM, FIFO bookkeeping and frame sync
  always_comb begin
    state_d     = state_q;
    kc_d        = keycode_in;
    cand_d      = cand_q;
    scnt_d      = scnt_q;
    cur_key_d   = cur_key_q;
    old_d       = old_q;
    new_d       = new_q;
    push_c      = 1'b0;
    push_data_c = '0;

    if (kc_q != cand_q) begin
      cand_d = kc_q;
      scnt_d = '0;
    end else if (scnt_q != SCNT_MAX) begin
      scnt_d = scnt_q + SCNT_W'(1);
    end

    // Saturated counter keeps the change pending until the FSM returns to IDLE
    change_c = (scnt_q == SCNT_MAX) && (cand_q != cur_key_q);

    case (state_q)
      IDLE: begin
        if (change_c) begin
          old_d     = cur_key_q;
          new_d     = cand_q;
          cur_key_d = cand_q;
          state_d   = (cur_key_q != 8'h00) ? REL : PRS;
        end
      end
      REL: begin
        push_c      = 1'b1;
        push_data_c = '{press: 1'b0, code: old_q};
        state_d     = (new_q != 8'h00) ? PRS : IDLE;
      end
      PRS: begin
        push_c      = 1'b1;
        push_data_c = '{press: 1'b1, code: new_q};
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    pop_c  = evt_valid_q && evt_ready;
    full_c = (count_q == OCC_FULL);
    wr_c   = push_c && (!full_c || pop_c);
    drop_c = push_c && full_c && !pop_c;

    wr_ptr_d    = wr_c  ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = pop_c ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d     = count_q + OCC_W'(wr_c) - OCC_W'(pop_c);
    evt_valid_d = (count_d != '0);

    if (drop_c)       overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    else              overflow_d = overflow_q;

    meta_d      = frame_vs;
    sync_d      = meta_q;
    tick_d      = sync_q && !meta_q;
    frame_key_d = tick_q ? cur_key_q : frame_key_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      kc_q        <= '0;
      cand_q      <= '0;
      scnt_q      <= '0;
      cur_key_q   <= '0;
      old_q       <= '0;
      new_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      meta_q      <= 1'b1;
      sync_q      <= 1'b1;
      tick_q      <= 1'b0;
      frame_key_q <= '0;
    end else begin
      state_q     <= state_d;
      kc_q        <= kc_d;
      cand_q      <= cand_d;
      scnt_q      <= scnt_d;
      cur_key_q   <= cur_key_d;
      old_q       <= old_d;
      new_q       <= new_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      overflow_q  <= overflow_d;
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      tick_q      <= tick_d;
      frame_key_q <= frame_key_d;
    end
  end

  // Event storage; cleared on reset so the head reads zero when empty
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (wr_c) begin
      mem_q[wr_ptr_q] <= push_data_c;
    end
  end

  assign evt_valid  = evt_valid_q;
  assign evt_data   = mem_q[rd_ptr_q];
  assign evt_count  = count_q;
  assign overflow   = overflow_q;
  assign frame_tick = tick_q;
  assign frame_key  = frame_key_q;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Scoreboard bench for keycode_event_queue: stimulus queues expected events,
// a negedge monitor pops and compares each event the DUT hands out.
module tb_keycode_event_queue;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [7:0] keycode_in;
  logic       frame_vs;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [8:0] evt_data;
  logic [3:0] evt_count;
  logic       overflow;
  logic       frame_tick;
  logic [7:0] frame_key;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q [$];
  logic [8:0] mon_exp;

  keycode_event_queue #(.DEPTH(8), .STABLE_CYC(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode_in(keycode_in), .frame_vs(frame_vs),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid),
    .evt_data(evt_data), .evt_count(evt_count), .overflow(overflow),
    .frame_tick(frame_tick), .frame_key(frame_key)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic key(input logic [7:0] k);
    keycode_in = k;
    step(10);
  endtask

  task automatic expect_evt(input logic p, input logic [7:0] c);
    exp_q.push_back({p, c});
  endtask

  task automatic drain(input int n);
    evt_ready = 1'b1;
    step(n);
    evt_ready = 1'b0;
  endtask

  // Monitor: every accepted pop must match the oldest expected event
  always @(negedge Clk) begin
    if (Reset_n && evt_valid && evt_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_evt: got %h want none", evt_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (evt_data !== mon_exp) begin
          errors++;
          $display("FAIL evt_order: got %h want %h", evt_data, mon_exp);
        end
      end
    end
  end

  initial begin
    int ticks;
    int lat;
    Reset_n    = 1'b0;
    keycode_in = 8'h00;
    frame_vs   = 1'b1;
    evt_ready  = 1'b0;
    ovf_clr    = 1'b0;
    step(3);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_data", evt_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_fkey", frame_key, 0);
    Reset_n = 1'b1;
    step(2);

    // 1) first press only
    expect_evt(1'b1, 8'h1A);
    key(8'h1A);
    chk("t1_count", evt_count, 1);
    chk("t1_data", evt_data, 9'h11A);
    drain(2);
    chk("t1_drained", evt_count, 0);

    // 2) key-to-key: release then press on consecutive cycles
    expect_evt(1'b0, 8'h1A);
    expect_evt(1'b1, 8'h07);
    keycode_in = 8'h07;
    step(7);
    chk("t2_rel_cycle", evt_count, 1);
    step(1);
    chk("t2_prs_cycle", evt_count, 2);
    chk("t2_head", evt_data, 9'h01A);
    step(2);
    drain(3);
    chk("t2_drained", evt_count, 0);

    // 3) short glitch is filtered
    expect_evt(1'b0, 8'h07);
    key(8'h00);
    drain(2);
    keycode_in = 8'h1A;
    step(3);
    keycode_in = 8'h00;
    step(12);
    chk("t3_glitch_count", evt_count, 0);
    chk("t3_glitch_valid", evt_valid, 0);

    // 4) overflow with nine key-to-key changes
    expect_evt(1'b1, 8'h10);
    key(8'h10);
    drain(2);
    for (int i = 0; i < 4; i++) begin
      expect_evt(1'b0, 8'(8'h10 + i));
      expect_evt(1'b1, 8'(8'h11 + i));
    end
    for (int i = 1; i <= 9; i++) key(8'(8'h10 + i));
    chk("t4_full_count", evt_count, 8);
    chk("t4_ovf", overflow, 1);
    chk("t4_head", evt_data, 9'h010);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", overflow, 0);
    expect_evt(1'b0, 8'h19);
    keycode_in = 8'h1A;
    step(6);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    chk("t4_push_pop_full", evt_count, 8);
    chk("t4_no_drop", overflow, 0);
    step(1);
    chk("t4_drop_count", evt_count, 8);
    chk("t4_drop_ovf", overflow, 1);
    step(2);
    drain(10);
    chk("t4_drained", evt_count, 0);
    chk("t4_sb_empty", exp_q.size(), 0);

    // 5) frame tick and frame-latched key (cur_key is 1A)
    evt_ready = 1'b1;
    ticks = 0;
    lat = 0;
    frame_vs = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (frame_tick) begin
        ticks++;
        if (lat == 0) lat = i;
      end
    end
    chk("t5_tick_count", ticks, 1);
    chk("t5_tick_latency_ok", (lat >= 2 && lat <= 3) ? 1 : 0, 1);
    chk("t5_fkey", frame_key, 8'h1A);
    expect_evt(1'b0, 8'h1A);
    expect_evt(1'b1, 8'h07);
    key(8'h07);
    chk("t5_fkey_midframe", frame_key, 8'h1A);
    frame_vs = 1'b1;
    step(5);
    chk("t5_fkey_vs_high", frame_key, 8'h1A);
    chk("t5_no_rise_tick", frame_tick, 0);
    frame_vs = 1'b0;
    step(6);
    chk("t5_fkey_next", frame_key, 8'h07);
    chk("t5_sb_empty", exp_q.size(), 0);

    // 6) reset with three queued events
    frame_vs  = 1'b1;
    step(4);
    evt_ready = 1'b0;
    key(8'h00);
    key(8'h1A);
    key(8'h00);
    chk("t6_queued", evt_count, 3);
    Reset_n = 1'b0;
    #2;
    chk("t6_rst_valid", evt_valid, 0);
    chk("t6_rst_count", evt_count, 0);
    step(2);
    Reset_n   = 1'b1;
    evt_ready = 1'b1;
    step(12);
    chk("t6_quiet_count", evt_count, 0);
    expect_evt(1'b1, 8'h3C);
    key(8'h3C);
    step(3);
    chk("t6_new_drained", evt_count, 0);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
